// File: rtl/decoder_3_8.sv
// Registered 3-to-8 decoder with enable, selectable output polarity and valid flag.
// Define DECODER_CHG_EN to add the registered code-change pulse output chg.
module decoder_3_8 #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   output logic [7:0] out,
   output logic       out_vld
`ifdef DECODER_CHG_EN
   ,
   output logic       chg
`endif
);

   logic [2:0] idx_p0;

   function automatic logic [7:0] decode(input logic [2:0] idx);
      logic [7:0] oh;
      oh = 8'h01 << idx;
      return ACTIVE_LOW ? ~oh : oh;
   endfunction

   function automatic logic [7:0] idle_code();
      return ACTIVE_LOW ? 8'hFF : 8'h00;
   endfunction

   assign idx_p0 = {a, b, c};

   // p0 -> p1: sample code on enabled edges, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         out     <= idle_code();
         out_vld <= 1'b0;
      end else if (en) begin
         out     <= decode(idx_p0);
         out_vld <= 1'b1;
      end
   end

`ifdef DECODER_CHG_EN
   logic [2:0] idx_p1;

   // out_vld doubles as "a code has been loaded since reset", so the first load always pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         chg    <= 1'b0;
         idx_p1 <= 3'd0;
      end else if (en) begin
         chg    <= !out_vld || (idx_p0 != idx_p1);
         idx_p1 <= idx_p0;
      end else begin
         chg    <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_3_8.sv
// Self-checking bench for decoder_3_8: table vectors, hand sequences and a random scoreboard run.
// Checks both polarities; checks chg when DECODER_CHG_EN is defined.
module tb_decoder_3_8;

   logic       clk = 1'b0;
   logic       rst, en, a, b, c;
   logic [7:0] out, out_n;
   logic       out_vld, out_vld_n;
   logic       chg, chg_n;

   always #5 clk = ~clk;

   decoder_3_8 #(.ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
      .out(out), .out_vld(out_vld)
`ifdef DECODER_CHG_EN
      , .chg(chg)
`endif
   );

   decoder_3_8 #(.ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
      .out(out_n), .out_vld(out_vld_n)
`ifdef DECODER_CHG_EN
      , .chg(chg_n)
`endif
   );

`ifndef DECODER_CHG_EN
   assign chg   = 1'b0;
   assign chg_n = 1'b0;
`endif

   typedef struct {
      logic       r;
      logic       e;
      logic [2:0] code;
      logic [7:0] eo;
      logic       ev;
   } vec_t;

   typedef struct {
      logic [7:0] eo;
      logic       ev;
      logic       ec;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // reference state
   logic [7:0] m_out = 8'h00;
   logic       m_vld = 1'b0;
   logic [2:0] m_idx = 3'd0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [2:0] code,
                       input logic [7:0] eo, input logic ev, input string nm);
      exp_t x;
      rst = r; en = e; {a, b, c} = code;
      x.eo = eo; x.ev = ev; x.nm = nm;
      x.ec = r ? 1'b0 : (e ? (!m_vld || code != m_idx) : 1'b0);
      if (r) begin
         m_out = 8'h00; m_vld = 1'b0;
      end else if (e) begin
         m_out = 8'h01 << code; m_vld = 1'b1; m_idx = code;
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({x.nm, ".out"},       out,              x.eo);
      chk({x.nm, ".vld"},       {7'd0, out_vld},  {7'd0, x.ev});
      chk({x.nm, ".out_n"},     out_n,            ~x.eo);
      chk({x.nm, ".vld_n"},     {7'd0, out_vld_n}, {7'd0, x.ev});
`ifdef DECODER_CHG_EN
      chk({x.nm, ".chg"},       {7'd0, chg},      {7'd0, x.ec});
      chk({x.nm, ".chg_n"},     {7'd0, chg_n},    {7'd0, x.ec});
`endif
   endtask

   initial begin
      vec_t vt[$];
      logic [7:0] held;
      rst = 1'b1; en = 1'b0; {a, b, c} = 3'b000;

      // reset, reset priority over en, held-off enable, then enable
      vt.push_back('{1'b1, 1'b0, 3'b000, 8'h00, 1'b0});
      vt.push_back('{1'b1, 1'b1, 3'b111, 8'h00, 1'b0});
      vt.push_back('{1'b0, 1'b0, 3'b101, 8'h00, 1'b0});
      vt.push_back('{1'b0, 1'b0, 3'b101, 8'h00, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'b101, 8'h20, 1'b1});
      // full sweep after a fresh reset
      vt.push_back('{1'b1, 1'b0, 3'b000, 8'h00, 1'b0});
      for (int i = 0; i < 8; i++)
         vt.push_back('{1'b0, 1'b1, 3'(i), 8'(8'h01 << i), 1'b1});
      // en low holds previous decode
      vt.push_back('{1'b0, 1'b0, 3'b010, 8'h80, 1'b1});
      vt.push_back('{1'b0, 1'b0, 3'b001, 8'h80, 1'b1});
      // reset mid-sweep while out=08, resume with 110
      for (int i = 0; i < 4; i++)
         vt.push_back('{1'b0, 1'b1, 3'(i), 8'(8'h01 << i), 1'b1});
      vt.push_back('{1'b1, 1'b1, 3'b100, 8'h00, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'b110, 8'h40, 1'b1});
      // hold 011 three cycles, change to 100, then en low
      for (int i = 0; i < 3; i++)
         vt.push_back('{1'b0, 1'b1, 3'b011, 8'h08, 1'b1});
      vt.push_back('{1'b0, 1'b1, 3'b100, 8'h10, 1'b1});
      vt.push_back('{1'b0, 1'b0, 3'b100, 8'h10, 1'b1});
      vt.push_back('{1'b0, 1'b0, 3'b111, 8'h10, 1'b1});

      for (int i = 0; i < vt.size(); i++)
         step(vt[i].r, vt[i].e, vt[i].code, vt[i].eo, vt[i].ev, $sformatf("vec%0d", i));

      // input wiggles between edges must not reach out
      step(1'b0, 1'b1, 3'b001, 8'h02, 1'b1, "pre_glitch");
      held = out;
      {a, b, c} = 3'b110; en = 1'b1;
      #2;
      chk("glitch.out", out, 8'h02);
      {a, b, c} = 3'b011; rst = 1'b1;
      #1;
      chk("glitch.out2", out, held);
      chk("glitch.out_n", out_n, 8'hFD);

      // random run against the reference model
      for (int i = 0; i < 1000; i++) begin
         logic       r, e;
         logic [2:0] code;
         logic [7:0] eo;
         logic       ev;
         r    = ($urandom_range(0, 49) == 0);
         e    = 1'($urandom_range(0, 1));
         code = 3'($urandom_range(0, 7));
         eo   = r ? 8'h00 : (e ? 8'(8'h01 << code) : m_out);
         ev   = r ? 1'b0 : (e ? 1'b1 : m_vld);
         step(r, e, code, eo, ev, "rnd");
         if (ev) begin
            tests++;
            if (!$onehot(out) || !$onehot(~out_n)) begin
               fails++;
               $display("FAIL rnd.onehot: got %h / %h required one-hot / one-cold", out, out_n);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
